// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;
  localparam int CNT_W      = 4;

  // Full 32-bit check: any set bit above the word index makes the access out of range.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[ADDR_LSB-1:0] != '0) || ({2'b00, addr[31:ADDR_LSB]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response channel between core memory stage and responder
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM with byte enables
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Read sees the pre-write contents when read and write hit the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[widx];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory target: FSM, request latch, error check, response
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               err_q;
  logic               load_ok_q;
  logic               commit;

  logic               c_we;
  logic [31:0]        c_addr;
  logic [31:0]        c_wdata;
  logic [3:0]         c_be;
  logic               c_err;
  logic [31:0]        arr_rdata;

  // With zero wait states the commit happens on the accept edge, so it must use the live inputs.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    if (state_q == IDLE) begin
      c_we    = bus.req_we;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
      c_be    = bus.req_be;
    end
  end

  assign c_err = addr_err(c_addr, DEPTH);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    commit        = 1'b0;
    bus.req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
      if (commit) begin
        err_q     <= c_err;
        load_ok_q <= !c_we && !c_err;
      end else if (state_q == RESP && bus.resp_ready) begin
        err_q     <= 1'b0;
        load_ok_q <= 1'b0;
      end
    end
  end

  // The array index stays on the latched address through RESP, so the read data holds.
  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (rst && commit && c_we && !c_err),
    .be    (c_be),
    .widx  (c_addr[ADDR_LSB +: IDX_W]),
    .wdata (c_wdata),
    .rdata (arr_rdata)
  );

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = load_ok_q ? arr_rdata : 32'h0;

endmodule
